// File: rtl/controller_sequencer.sv
// SAP-1 control unit: six-state one-hot ring counter with opcode decode of the control word.
// Define CTRL_VARIABLE_CYCLE_EN to end each instruction after its last non-empty T-state.
module controller_sequencer #(
    parameter int unsigned T_STATES = 6
) (
    input  logic                CLK,
    input  logic                CLR,
    input  logic [3:0]          opcode,
    output logic [T_STATES-1:0] t_state,
    output logic                Cp,
    output logic                Ep,
    output logic                Lm,
    output logic                CE,
    output logic                Li,
    output logic                Ei,
    output logic                La,
    output logic                Ea,
    output logic                Su,
    output logic                Eu,
    output logic                Lb,
    output logic                Lo,
    output logic                HLT
);

    localparam logic [3:0] OpLda = 4'b0000;
    localparam logic [3:0] OpAdd = 4'b0001;
    localparam logic [3:0] OpSub = 4'b0010;
    localparam logic [3:0] OpOut = 4'b1110;
    localparam logic [3:0] OpHlt = 4'b1111;

    typedef enum logic [T_STATES-1:0] {
        StT1 = 6'b000001,
        StT2 = 6'b000010,
        StT3 = 6'b000100,
        StT4 = 6'b001000,
        StT5 = 6'b010000,
        StT6 = 6'b100000
    } ring_e;

    ring_e ring_q, ring_d;
    logic  halted_q, halted_d;

    logic is_lda, is_add, is_sub, is_out, is_hlt;

    always_comb begin
        is_lda = (opcode == OpLda);
        is_add = (opcode == OpAdd);
        is_sub = (opcode == OpSub);
        is_out = (opcode == OpOut);
        is_hlt = (opcode == OpHlt);
    end

    // Ring advance; a halt freezes the ring on T4 until CLR.
    always_comb begin
        ring_d   = ring_q;
        halted_d = halted_q;
        if (halted_q) begin
            ring_d = ring_q;
        end else if ((ring_q == StT4) && is_hlt) begin
            halted_d = 1'b1;
        end else begin
            case (ring_q)
                StT1: ring_d = StT2;
                StT2: ring_d = StT3;
                StT3: ring_d = StT4;
`ifdef CTRL_VARIABLE_CYCLE_EN
                StT4: ring_d = (is_lda || is_add || is_sub) ? StT5 : StT1;
                StT5: ring_d = is_lda ? StT1 : StT6;
`else
                StT4: ring_d = StT5;
                StT5: ring_d = StT6;
`endif
                StT6: ring_d = StT1;
                default: ring_d = StT1;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            ring_q   <= StT1;
            halted_q <= 1'b0;
        end else begin
            ring_q   <= ring_d;
            halted_q <= halted_d;
        end
    end

    assign t_state = ring_q;

    // Control word decode; everything is forced low once halted.
    always_comb begin
        Cp = 1'b0;
        Ep = 1'b0;
        Lm = 1'b0;
        CE = 1'b0;
        Li = 1'b0;
        Ei = 1'b0;
        La = 1'b0;
        Ea = 1'b0;
        Su = 1'b0;
        Eu = 1'b0;
        Lb = 1'b0;
        Lo = 1'b0;
        HLT = halted_q || ((ring_q == StT4) && is_hlt);
        if (!halted_q) begin
            case (ring_q)
                StT1: begin
                    Ep = 1'b1;
                    Lm = 1'b1;
                end
                StT2: Cp = 1'b1;
                StT3: begin
                    CE = 1'b1;
                    Li = 1'b1;
                end
                StT4: begin
                    if (is_lda || is_add || is_sub) begin
                        Ei = 1'b1;
                        Lm = 1'b1;
                    end else if (is_out) begin
                        Ea = 1'b1;
                        Lo = 1'b1;
                    end
                    Su = is_sub;
                end
                StT5: begin
                    if (is_lda) begin
                        CE = 1'b1;
                        La = 1'b1;
                    end else if (is_add || is_sub) begin
                        CE = 1'b1;
                        Lb = 1'b1;
                    end
                    Su = is_sub;
                end
                StT6: begin
                    if (is_add || is_sub) begin
                        Eu = 1'b1;
                        La = 1'b1;
                    end
                    Su = is_sub;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_controller_sequencer.sv
// Randomized bench for controller_sequencer against an instruction-level reference model.
module tb_controller_sequencer;

    logic       CLK;
    logic       CLR;
    logic [3:0] opcode;
    logic [5:0] t_state;
    logic Cp, Ep, Lm, CE, Li, Ei, La, Ea, Su, Eu, Lb, Lo, HLT;

    controller_sequencer #(.T_STATES(6)) dut (
        .CLK(CLK), .CLR(CLR), .opcode(opcode), .t_state(t_state),
        .Cp(Cp), .Ep(Ep), .Lm(Lm), .CE(CE), .Li(Li), .Ei(Ei), .La(La), .Ea(Ea),
        .Su(Su), .Eu(Eu), .Lb(Lb), .Lo(Lo), .HLT(HLT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Bit positions in the packed control word.
    localparam int BCP = 12, BEP = 11, BLM = 10, BCE = 9, BLI = 8, BEI = 7, BLA = 6;
    localparam int BEA = 5, BSU = 4, BEU = 3, BLB = 2, BLO = 1, BHL = 0;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: T-state number 1..6 and halt flag.
    int         m_t     = 1;
    logic       m_halt  = 1'b0;
    logic       m_valid = 1'b0;
    logic [3:0] cur_op  = 4'h0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0d op=%h halt=%0b)",
                     tag, got, exp, m_t, cur_op, m_halt);
        end
    endtask

    function automatic int instr_len(input logic [3:0] op);
`ifdef CTRL_VARIABLE_CYCLE_EN
        case (op)
            4'h0:       return 5;
            4'h1, 4'h2: return 6;
            default:    return 4;
        endcase
`else
        return 6;
`endif
    endfunction

    function automatic logic [12:0] exp_word(input int t, input logic halt, input logic [3:0] op);
        logic [12:0] w;
        w = '0;
        if (halt) begin
            w[BHL] = 1'b1;
            return w;
        end
        case (t)
            1: begin w[BEP] = 1'b1; w[BLM] = 1'b1; end
            2: w[BCP] = 1'b1;
            3: begin w[BCE] = 1'b1; w[BLI] = 1'b1; end
            default: begin
                case (op)
                    4'h0: begin
                        if (t == 4) begin w[BEI] = 1'b1; w[BLM] = 1'b1; end
                        if (t == 5) begin w[BCE] = 1'b1; w[BLA] = 1'b1; end
                    end
                    4'h1, 4'h2: begin
                        if (t == 4) begin w[BEI] = 1'b1; w[BLM] = 1'b1; end
                        if (t == 5) begin w[BCE] = 1'b1; w[BLB] = 1'b1; end
                        if (t == 6) begin w[BEU] = 1'b1; w[BLA] = 1'b1; end
                        w[BSU] = (op == 4'h2);
                    end
                    4'hE: if (t == 4) begin w[BEA] = 1'b1; w[BLO] = 1'b1; end
                    4'hF: if (t == 4) w[BHL] = 1'b1;
                    default: ;
                endcase
            end
        endcase
        return w;
    endfunction

    task automatic step(input logic clr);
        logic [12:0] got_w;
        logic [5:0]  exp_t;
        @(negedge CLK);
        CLR    = clr;
        opcode = cur_op;
        #1;
        if (m_valid) begin
            got_w = {Cp, Ep, Lm, CE, Li, Ei, La, Ea, Su, Eu, Lb, Lo, HLT};
            exp_t = m_halt ? 6'b001000 : 6'(1 << (m_t - 1));
            check_eq("t_state", 32'(t_state), 32'(exp_t));
            check_eq("ctrl", 32'(got_w), 32'(exp_word(m_t, m_halt, cur_op)));
            check_eq("bus_excl", 32'($countones({Ep, CE, Ei, Ea, Eu}) <= 1), 32'd1);
        end
        @(posedge CLK);
        if (clr) begin
            m_t     = 1;
            m_halt  = 1'b0;
            m_valid = 1'b1;
        end else if (m_valid && !m_halt) begin
            if (m_t == 4 && cur_op == 4'hF) m_halt = 1'b1;
            else if (m_t >= instr_len(cur_op)) m_t = 1;
            else m_t++;
        end
    endtask

    task automatic run_instr(input logic [3:0] op);
        cur_op = op;
        for (int i = 0; i < 8; i++) begin
            step(1'b0);
            if (m_t == 1 || m_halt) break;
        end
    endtask

    initial begin
        logic [3:0] pick [8];
        logic       clr;
        pick = '{4'h0, 4'h1, 4'h2, 4'hE, 4'hF, 4'h5, 4'h3, 4'h9};
        CLR    = 1'b1;
        opcode = 4'h0;

        step(1'b1);
        step(1'b1);

        run_instr(4'h0);
        run_instr(4'h1);
        run_instr(4'h2);
        run_instr(4'hE);
        run_instr(4'h5);

        // CLR during T5 of ADD.
        cur_op = 4'h1;
        repeat (4) step(1'b0);
        check_eq("clr_at_t5_setup", 32'(m_t), 32'd5);
        step(1'b1);
        step(1'b0);

        // Fill to T1, then halt and sit.
        for (int i = 0; i < 8 && m_t != 1; i++) step(1'b0);
        run_instr(4'hF);
        check_eq("halted_model", 32'(m_halt), 32'd1);
        repeat (10) begin
            cur_op = 4'($urandom_range(0, 15));
            step(1'b0);
        end
        step(1'b1);
        cur_op = 4'h0;
        step(1'b0);

        for (int c = 0; c < 1500; c++) begin
            if (m_t == 1 && !m_halt) cur_op = pick[$urandom_range(0, 7)];
            clr = m_halt ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 59) == 0);
            step(clr);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/controller_sequencer.md
# controller_sequencer

SAP-1 control unit: a six-state ring counter plus an instruction decoder that drives the control word for every bus participant. It is the initiator of the Su/Eu interface consumed by the ALU, and of the load/enable strobes for the PC, MAR, RAM, IR, accumulator, B register and output register. It sits between the instruction register's opcode nibble and the datapath. One instruction completes per machine cycle.

## Interface
Parameters:
- T_STATES, 6: ring length; fixed at 6 for SAP-1; other values are unsupported.

Ports (all control outputs are active-high):
- CLK  in  1  system clock; all state changes on the rising edge.
- CLR  in  1  reset; synchronous, active-high.
- opcode  in  4  IR[7:4]; must be stable from T4 through T6.
- t_state  out  6  one-hot ring state; bit0 = T1 … bit5 = T6.
- Cp  out  1  PC increment.
- Ep  out  1  PC drives WBUS.
- Lm  out  1  MAR load.
- CE  out  1  RAM drives WBUS.
- Li  out  1  IR load.
- Ei  out  1  IR operand nibble drives WBUS.
- La  out  1  accumulator load.
- Ea  out  1  accumulator drives WBUS.
- Su  out  1  ALU operation: 0 = add, 1 = subtract.
- Eu  out  1  ALU drives WBUS.
- Lb  out  1  B register load.
- Lo  out  1  output register load.
- HLT  out  1  machine halted; the clock gate uses it.

## Operation
- Opcodes:
  - LDA = 4'b0000
  - ADD = 4'b0001
  - SUB = 4'b0010
  - OUT = 4'b1110
  - HLT = 4'b1111
  - Any other value is a NOP, with no control asserted in T4–T6.
- Registered state: the one-hot ring and a `halted` flag. All control outputs decode combinationally from the ring, `halted` and opcode.
- Fetch, for every opcode:
  - T1: Ep, Lm
  - T2: Cp
  - T3: CE, Li
- Execute:
  - LDA: T4 Ei, Lm; T5 CE, La; T6 none.
  - ADD: T4 Ei, Lm; T5 CE, Lb; T6 Eu, La.
  - SUB: same as ADD. Su is held at 1 throughout T4–T6.
  - OUT: T4 Ea, Lo; T5 and T6 none.
  - HLT: in T4, the ring does not advance. `halted` sets on that edge.
- Su is 0 in every state except SUB T4–T6.
- Bus exclusivity invariant: at most one of Ep, CE, Ei, Ea, Eu is high in any cycle.
- Halted state:
  - All control outputs are 0.
  - HLT = 1.
  - t_state holds T4.
  - Only CLR exits this state.

## Timing
- On reset (CLR high at an edge): t_state = 6'b000001 (T1), halted = 0, HLT = 0. All controls follow T1 decode, so Ep = Lm = 1 and everything else is 0.
- CLR has priority over every other event, including HLT decode and a mid-instruction state. The ring restarts at T1 on the next cycle.
- Ring advance: T1→T2→…→T6→T1, one T-state per cycle. The default machine cycle is exactly 6 clocks.
- Output latency: controls are valid combinationally within the same cycle as the t_state they belong to. There are no registered outputs.
- Loads take effect at the edge that ends the T-state in which they are asserted. Example: Li high in T3 means the IR captures at the T3→T4 edge, so opcode is valid from T4.
- HLT output: rises combinationally in T4 when opcode = HLT, and stays high from the next edge on. Cp is never asserted after halt, so the PC freezes.
- Wrap-around: T6→T1 needs no extra cycle. The next fetch starts immediately.

## Configuration
- CTRL_VARIABLE_CYCLE_EN:
  - Defined: the ring returns to T1 directly after the last non-empty execute state.
    - OUT and NOP: T4→T1 (4-cycle instruction).
    - LDA: T5→T1 (5 cycles).
    - ADD and SUB: 6 cycles.
    - HLT behaviour is unchanged.
  - Undefined: every instruction takes a fixed 6 cycles.

## Test plan
- Reset: hold CLR for 2 cycles, then release. Required: t_state = 000001, Ep = Lm = 1, HLT = 0; then T2 with Cp = 1 only, then T3 with CE = Li = 1.
- LDA (opcode 0000): required T4 {Ei, Lm}, T5 {CE, La}, T6 all zero. Su = 0 in every state. Back at T1 after 6 cycles, or 5 with CTRL_VARIABLE_CYCLE_EN.
- ADD then SUB (0001, 0010): required T6 {Eu, La}, with Su = 0 for ADD and Su = 1 for SUB in T4–T6. T5 {CE, Lb} in both.
- OUT (1110): required T4 {Ea, Lo}. T5 and T6 all zero, or T4→T1 with the macro defined. Also run an unused opcode (0101): required all controls 0 in T4–T6.
- HLT (1111): required HLT = 1 in T4. After 10 further clocks, t_state is still 001000 and all controls are 0. Asserting CLR then gives T1 with HLT = 0.
- CLR asserted in T5 of ADD: required T1 on the next cycle, Lb never re-asserted, no stray La. Across all runs, assert the bus exclusivity invariant every cycle.
